hazard_stall_ctrl: RTL and testbench
====================================

HAZARD_STALL_CTRL -- requirements
Module: hazard_stall_ctrl

Interface
REQ-001 Parameter REG_AW, default 5, register address width.
REQ-002 Parameter NSRC, default 2, number of source-operand ports checked per ID instruction (1..4).
REQ-003 Parameter LOAD_LAT, default 2, cycles from load in EX until data forwardable to ID compare (2..4).
REQ-004 Parameter CNT_W, default 16, statistics counter width.
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 RESET  in  1  synchronous, active-high reset.
REQ-007 ID_Valid  in  1  ID stage holds a real instruction.
REQ-008 ID_Src  in  NSRC*REG_AW  packed source register numbers, port k at bits [k*REG_AW +: REG_AW].
REQ-009 ID_Src_Used  in  NSRC  per-port flag: source k actually read.
REQ-010 ID_Is_Branch  in  1  ID instruction compares operands in ID (beq/bne/jr).
REQ-011 ID_Jump  in  1  ID instruction is j/jal/jr.
REQ-012 Branch_Taken  in  1  ID branch compare result.
REQ-013 EX_RegWrite, EX_MemRead  in  1 each; EX_RD  in  REG_AW.
REQ-014 MEM_RegWrite, MEM_MemRead  in  1 each; MEM_RD  in  REG_AW.
REQ-015 Stats_Clear  in  1  clears statistics counters.
REQ-016 PCWrite, IFIDWrite  out  1  PC / IF-ID register enables.
REQ-017 IF_Flush  out  1  zero IF-ID on next edge.
REQ-018 Hazard_Ctrl  out  1  insert bubble (zero control) into ID-EX.
REQ-019 Stall_Count, Flush_Count  out  CNT_W each  statistics.

Function
REQ-020 Match on port k: ID_Valid & ID_Src_Used[k] & src_k != 0 & src_k == producer RD & producer RegWrite; register 0 never matches.
REQ-021 Required stall depth d = max over matches: non-branch with EX load -> LOAD_LAT-1; branch with EX non-load -> 1; branch with EX load -> LOAD_LAT; branch with MEM load -> LOAD_LAT-1; no match -> 0.
REQ-022 States RUN and STALL; 2-bit down-counter cnt.
REQ-023 RUN, d=0: stall=0. RUN, d=1: stall=1, stay RUN. RUN, d>1: stall=1, next STALL with cnt=d-1.
REQ-024 STALL: stall=1, inputs ignored; cnt decrements each cycle; cnt==1 -> next RUN, cnt=0.
REQ-025 stall=1 -> PCWrite=0, IFIDWrite=0, Hazard_Ctrl=1; stall=0 -> PCWrite=1, IFIDWrite=1, Hazard_Ctrl=0; combinational, same-cycle as detection.
REQ-026 IF_Flush=1 only when stall=0 & ID_Valid & (ID_Jump | (ID_Is_Branch & Branch_Taken)); one cycle per instruction; never asserted during stall.
REQ-027 ID_Valid=0 -> no stall, no flush, regardless of other inputs.

Reset
REQ-028 RESET sampled high -> state RUN, cnt=0, next cycle outputs per REQ-025 with fresh evaluation.
REQ-029 While RESET high: PCWrite=0, IFIDWrite=0, IF_Flush=0, Hazard_Ctrl=1.
REQ-030 RESET mid-STALL abandons remaining stall cycles; counters cleared (if present).

Configuration
REQ-031 Macro HAZARD_STATS_EN defined: Stall_Count +1 per stall=1 cycle, Flush_Count +1 per IF_Flush cycle, both saturate at all-ones, Stats_Clear zeroes both (priority over increment).
REQ-032 HAZARD_STATS_EN undefined: ports remain, both tied to 0, no counter flops.

Verification
REQ-033 Defaults; EX lw RD=8 (RegWrite, MemRead), ID add src0=8 used -> one stall cycle (PCWrite=0, Hazard_Ctrl=1), then PCWrite=1.
REQ-034 EX lw RD=10, ID beq src1=10, LOAD_LAT=2 -> stall 2 consecutive cycles via STALL state, then RUN, no flush until compare resolves.
REQ-035 EX add RD=9, ID beq src0=9 -> 1 stall; next cycle Branch_Taken=1 -> IF_Flush=1 exactly one cycle.
REQ-036 ID j, no matches -> IF_Flush=1, PCWrite=1; EX_RD=0 with RegWrite, src=0 -> no stall.
REQ-037 LOAD_LAT=4, branch vs EX load -> 4 stall cycles; RESET after 2nd -> outputs per REQ-029, then RUN with no residual stall.
REQ-038 HAZARD_STATS_EN, CNT_W=4: 20 stall cycles -> Stall_Count=15; Stats_Clear -> 0 next cycle.

Source files
------------

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: load-use and ID-branch interlock with bubble/flush control.
// Optional saturating stall/flush counters when HAZARD_STATS_EN is defined.
module hazard_stall_ctrl #(
  parameter int REG_AW   = 5,
  parameter int NSRC     = 2,
  parameter int LOAD_LAT = 2,
  parameter int CNT_W    = 16
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   ID_Valid,
  input  logic [NSRC*REG_AW-1:0] ID_Src,
  input  logic [NSRC-1:0]        ID_Src_Used,
  input  logic                   ID_Is_Branch,
  input  logic                   ID_Jump,
  input  logic                   Branch_Taken,
  input  logic                   EX_RegWrite,
  input  logic                   EX_MemRead,
  input  logic [REG_AW-1:0]      EX_RD,
  input  logic                   MEM_RegWrite,
  input  logic                   MEM_MemRead,
  input  logic [REG_AW-1:0]      MEM_RD,
  input  logic                   Stats_Clear,
  output logic                   PCWrite,
  output logic                   IFIDWrite,
  output logic                   IF_Flush,
  output logic                   Hazard_Ctrl,
  output logic [CNT_W-1:0]       Stall_Count,
  output logic [CNT_W-1:0]       Flush_Count
);

  typedef enum logic {RUN, STALL} state_t;

  localparam logic [2:0] LAT = 3'(LOAD_LAT);

  state_t     state;
  logic [1:0] cnt;
  logic [2:0] dep [NSRC];
  logic [2:0] depth;
  logic       stall;
  logic       flush;

  for (genvar k = 0; k < NSRC; k++) begin : g_src
    logic [REG_AW-1:0] src;
    logic              rd_ok;
    logic              hit_ex;
    logic              hit_mem;
    logic [2:0]        d_ex;
    logic [2:0]        d_mem;

    assign src     = ID_Src[k*REG_AW +: REG_AW];
    assign rd_ok   = ID_Valid & ID_Src_Used[k] & (src != '0);
    assign hit_ex  = rd_ok & EX_RegWrite & (src == EX_RD);
    assign hit_mem = rd_ok & MEM_RegWrite & (src == MEM_RD);

    always_comb begin
      d_ex = 3'd0;
      unique case (1'b1)
        hit_ex & EX_MemRead & ID_Is_Branch:   d_ex = LAT;
        hit_ex & EX_MemRead & ~ID_Is_Branch:  d_ex = LAT - 3'd1;
        hit_ex & ~EX_MemRead & ID_Is_Branch:  d_ex = 3'd1;
        default:                              d_ex = 3'd0;
      endcase
    end

    // ALU results in MEM forward to ID in time; only loads still pending
    assign d_mem = (hit_mem & MEM_MemRead & ID_Is_Branch) ?
                   LAT - 3'd1 : 3'd0;

    assign dep[k] = (d_ex > d_mem) ? d_ex : d_mem;
  end

  always_comb begin
    depth = 3'd0;
    for (int k = 0; k < NSRC; k++) begin
      if (dep[k] > depth) depth = dep[k];
    end
  end

  assign stall = (state == STALL) | (depth != 3'd0);
  assign flush = ~stall & ID_Valid &
                 (ID_Jump | (ID_Is_Branch & Branch_Taken));

  always_comb begin
    PCWrite     = 1'b0;
    IFIDWrite   = 1'b0;
    IF_Flush    = 1'b0;
    Hazard_Ctrl = 1'b1;
    if (!RESET) begin
      PCWrite     = ~stall;
      IFIDWrite   = ~stall;
      IF_Flush    = flush;
      Hazard_Ctrl = stall;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state <= RUN;
      cnt   <= 2'd0;
    end else begin
      case (state)
        RUN: begin
          if (depth > 3'd1) begin
            state <= STALL;
            cnt   <= 2'(depth - 3'd1);
          end
        end
        STALL: begin
          if (cnt == 2'd1) begin
            state <= RUN;
            cnt   <= 2'd0;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        default: begin
          state <= RUN;
          cnt   <= 2'd0;
        end
      endcase
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge CLK) begin
    if (RESET || Stats_Clear) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (stall && (Stall_Count != '1)) Stall_Count <= Stall_Count + 1'b1;
      if (flush && (Flush_Count != '1)) Flush_Count <= Flush_Count + 1'b1;
    end
  end
`else
  logic unused_stats;
  assign unused_stats = Stats_Clear;
  assign Stall_Count  = '0;
  assign Flush_Count  = '0;
`endif

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: vector table plus multi-cycle sequences,
// expected values queued on drive and checked on the falling edge.
module tb_hazard_stall_ctrl;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic        RESET;
  logic        ID_Valid;
  logic [9:0]  ID_Src;
  logic [1:0]  ID_Src_Used;
  logic        ID_Is_Branch;
  logic        ID_Jump;
  logic        Branch_Taken;
  logic        EX_RegWrite;
  logic        EX_MemRead;
  logic [4:0]  EX_RD;
  logic        MEM_RegWrite;
  logic        MEM_MemRead;
  logic [4:0]  MEM_RD;
  logic        Stats_Clear;

  logic        pcw0, ifw0, fl0, hz0;
  logic [15:0] sc0, fc0;
  logic        pcw4, ifw4, fl4, hz4;
  logic [15:0] sc4, fc4;
  logic        pcws, ifws, fls, hzs;
  logic [3:0]  scs, fcs;

`ifdef HAZARD_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  hazard_stall_ctrl u0 (
    .CLK(CLK), .RESET(RESET), .ID_Valid(ID_Valid), .ID_Src(ID_Src),
    .ID_Src_Used(ID_Src_Used), .ID_Is_Branch(ID_Is_Branch),
    .ID_Jump(ID_Jump), .Branch_Taken(Branch_Taken),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RD(EX_RD),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_RD(MEM_RD), .Stats_Clear(Stats_Clear),
    .PCWrite(pcw0), .IFIDWrite(ifw0), .IF_Flush(fl0),
    .Hazard_Ctrl(hz0), .Stall_Count(sc0), .Flush_Count(fc0)
  );

  hazard_stall_ctrl #(.LOAD_LAT(4)) u4 (
    .CLK(CLK), .RESET(RESET), .ID_Valid(ID_Valid), .ID_Src(ID_Src),
    .ID_Src_Used(ID_Src_Used), .ID_Is_Branch(ID_Is_Branch),
    .ID_Jump(ID_Jump), .Branch_Taken(Branch_Taken),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RD(EX_RD),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_RD(MEM_RD), .Stats_Clear(Stats_Clear),
    .PCWrite(pcw4), .IFIDWrite(ifw4), .IF_Flush(fl4),
    .Hazard_Ctrl(hz4), .Stall_Count(sc4), .Flush_Count(fc4)
  );

  hazard_stall_ctrl #(.CNT_W(4)) us (
    .CLK(CLK), .RESET(RESET), .ID_Valid(ID_Valid), .ID_Src(ID_Src),
    .ID_Src_Used(ID_Src_Used), .ID_Is_Branch(ID_Is_Branch),
    .ID_Jump(ID_Jump), .Branch_Taken(Branch_Taken),
    .EX_RegWrite(EX_RegWrite), .EX_MemRead(EX_MemRead), .EX_RD(EX_RD),
    .MEM_RegWrite(MEM_RegWrite), .MEM_MemRead(MEM_MemRead),
    .MEM_RD(MEM_RD), .Stats_Clear(Stats_Clear),
    .PCWrite(pcws), .IFIDWrite(ifws), .IF_Flush(fls),
    .Hazard_Ctrl(hzs), .Stall_Count(scs), .Flush_Count(fcs)
  );

  typedef struct {
    logic       v;
    logic [4:0] s0;
    logic [4:0] s1;
    logic [1:0] u;
    logic       br;
    logic       jp;
    logic       tk;
    logic       ew;
    logic       er;
    logic [4:0] erd;
    logic       mw;
    logic       mr;
    logic [4:0] mrd;
    logic [3:0] e;
  } vec_t;

  typedef struct {
    string       nm;
    int          sel;
    logic [15:0] exp;
  } exp_t;

  exp_t  sb[$];
  int    ntest = 0;
  int    nfail = 0;
  vec_t  tv[17];
  string names[17];
  vec_t  idle_v, jump_v, v;

  function automatic logic [15:0] actual(input int sel);
    case (sel)
      0:       return {12'd0, pcw0, ifw0, fl0, hz0};
      1:       return {12'd0, pcw4, ifw4, fl4, hz4};
      2:       return {12'd0, scs};
      3:       return {12'd0, fcs};
      default: return 16'hdead;
    endcase
  endfunction

  task automatic drive(input vec_t x);
    ID_Valid     = x.v;
    ID_Src       = {x.s1, x.s0};
    ID_Src_Used  = x.u;
    ID_Is_Branch = x.br;
    ID_Jump      = x.jp;
    Branch_Taken = x.tk;
    EX_RegWrite  = x.ew;
    EX_MemRead   = x.er;
    EX_RD        = x.erd;
    MEM_RegWrite = x.mw;
    MEM_MemRead  = x.mr;
    MEM_RD       = x.mrd;
  endtask

  task automatic expect_v(input int sel, input logic [15:0] e,
                          input string nm);
    exp_t x;
    x.nm  = nm;
    x.sel = sel;
    x.exp = e;
    sb.push_back(x);
  endtask

  task automatic settle();
    exp_t        x;
    logic [15:0] act;
    @(negedge CLK);
    while (sb.size() != 0) begin
      x   = sb.pop_front();
      act = actual(x.sel);
      ntest++;
      if (act !== x.exp) begin
        nfail++;
        $display("FAIL %s: got %h expected %h", x.nm, act, x.exp);
      end
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic cycle(input int sel, input vec_t x, input string nm);
    drive(x);
    expect_v(sel, {12'd0, x.e}, nm);
    settle();
    tick();
  endtask

  task automatic rst();
    RESET = 1'b1;
    drive(idle_v);
    tick();
    RESET = 1'b0;
  endtask

  initial begin
    // fields: v s0 s1 u br jp tk ew er erd mw mr mrd {pcw,ifw,flush,hz}
    idle_v = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100};
    jump_v = '{1, 3, 4, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 4'b1110};

    tv[0]  = idle_v;                                                names[0]  = "idle";
    tv[1]  = '{1, 8, 0, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0, 4'b0001};     names[1]  = "load_use";
    tv[2]  = '{1, 8, 0, 0, 0, 0, 0, 1, 1, 8, 0, 0, 0, 4'b1100};     names[2]  = "src_unused";
    tv[3]  = '{1, 9, 0, 1, 0, 0, 0, 1, 0, 9, 0, 0, 0, 4'b1100};     names[3]  = "ex_alu_fwd";
    tv[4]  = '{1, 9, 0, 1, 1, 0, 0, 1, 0, 9, 0, 0, 0, 4'b0001};     names[4]  = "br_ex_alu";
    tv[5]  = '{1, 0, 0, 3, 1, 0, 0, 1, 1, 0, 0, 0, 0, 4'b1100};     names[5]  = "reg0_never";
    tv[6]  = jump_v;                                                names[6]  = "jump_flush";
    tv[7]  = '{1, 3, 4, 3, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1110};     names[7]  = "br_taken";
    tv[8]  = '{1, 3, 4, 3, 1, 0, 0, 0, 0, 0, 0, 0, 0, 4'b1100};     names[8]  = "br_not_taken";
    tv[9]  = '{0, 8, 0, 1, 1, 1, 1, 1, 1, 8, 0, 0, 0, 4'b1100};     names[9]  = "id_invalid";
    tv[10] = '{1, 8, 0, 1, 0, 0, 0, 0, 1, 8, 0, 0, 0, 4'b1100};     names[10] = "no_regwrite";
    tv[11] = '{1, 0, 7, 2, 0, 0, 0, 0, 0, 0, 1, 1, 7, 4'b1100};     names[11] = "mem_ld_alu";
    tv[12] = '{1, 0, 7, 2, 1, 0, 0, 0, 0, 0, 1, 1, 7, 4'b0001};     names[12] = "mem_ld_br";
    tv[13] = '{1, 0, 7, 2, 1, 0, 0, 0, 0, 0, 1, 0, 7, 4'b1100};     names[13] = "mem_alu_br";
    tv[14] = '{1, 9, 0, 1, 1, 0, 1, 1, 0, 9, 0, 0, 0, 4'b0001};     names[14] = "stall_no_flush";
    tv[15] = '{1, 0, 31, 2, 0, 0, 0, 1, 1, 31, 0, 0, 0, 4'b0001};   names[15] = "port1_load";
    tv[16] = '{1, 8, 0, 1, 0, 0, 0, 1, 1, 9, 0, 0, 0, 4'b1100};     names[16] = "rd_mismatch";

    Stats_Clear = 1'b0;
    RESET       = 1'b1;
    drive(jump_v);
    expect_v(0, 16'h0001, "reset_u0");
    expect_v(1, 16'h0001, "reset_u4");
    expect_v(2, 16'h0000, "reset_stall_cnt");
    expect_v(3, 16'h0000, "reset_flush_cnt");
    settle();
    tick();
    RESET = 1'b0;

    for (int i = 0; i < 17; i++) cycle(0, tv[i], names[i]);

    rst();
    v = '{1, 8, 0, 1, 0, 0, 0, 1, 1, 8, 0, 0, 0, 4'b0001};
    cycle(0, v, "lw_stall");
    v = '{1, 8, 0, 1, 0, 0, 0, 0, 0, 0, 1, 1, 8, 4'b1100};
    cycle(0, v, "lw_resume");

    rst();
    v = '{1, 0, 10, 2, 1, 0, 0, 1, 1, 10, 0, 0, 0, 4'b0001};
    cycle(0, v, "br_ld_st1");
    v = '{1, 0, 10, 2, 1, 0, 1, 0, 0, 0, 1, 1, 10, 4'b0001};
    cycle(0, v, "br_ld_st2_noflush");
    v = '{1, 0, 10, 2, 1, 0, 1, 0, 0, 0, 0, 0, 0, 4'b1110};
    cycle(0, v, "br_ld_resolve");
    cycle(0, idle_v, "br_ld_after");

    rst();
    v = '{1, 9, 0, 1, 1, 0, 0, 1, 0, 9, 0, 0, 0, 4'b0001};
    cycle(0, v, "br_alu_stall");
    v = '{1, 9, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 9, 4'b1110};
    cycle(0, v, "br_alu_flush");
    cycle(0, idle_v, "br_alu_one_shot");

    rst();
    v = '{1, 0, 10, 2, 1, 0, 0, 1, 1, 10, 0, 0, 0, 4'b0001};
    for (int i = 0; i < 4; i++) cycle(1, v, $sformatf("lat4_stall%0d", i));
    cycle(1, idle_v, "lat4_run");

    rst();
    cycle(1, v, "lat4_rst_st1");
    cycle(1, v, "lat4_rst_st2");
    RESET = 1'b1;
    drive(jump_v);
    expect_v(1, 16'h0001, "lat4_in_reset");
    settle();
    tick();
    RESET = 1'b0;
    cycle(1, idle_v, "lat4_no_residual");
    cycle(1, jump_v, "lat4_run_flush");

    rst();
    drive(tv[1]);
    repeat (3) tick();
    expect_v(2, STATS ? 16'd3 : 16'd0, "stall_cnt_3");
    settle();
    repeat (17) tick();
    expect_v(2, STATS ? 16'd15 : 16'd0, "stall_cnt_sat");
    settle();
    Stats_Clear = 1'b1;
    drive(idle_v);
    tick();
    Stats_Clear = 1'b0;
    expect_v(2, 16'd0, "stall_cnt_clear");
    settle();
    drive(jump_v);
    repeat (2) tick();
    drive(idle_v);
    expect_v(3, STATS ? 16'd2 : 16'd0, "flush_cnt_2");
    expect_v(2, 16'd0, "stall_cnt_idle");
    settle();

    $display("[TB] %0d tests run, %0d failed", ntest, nfail);
    $finish;
  end

endmodule
